meas_sequencer: RTL



---
 rtl/meas_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/meas_sequencer.sv
// Measurement sequencer: clears the ring-oscillator counters, opens a counting gate,
// lets the counts settle, then loads and shifts out each channel to the readout.
module meas_sequencer #(
  parameter int GATE_WIDTH    = 16,
  parameter int FRAME_BITS    = 24,
  parameter int CLEAR_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int CHANNELS      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  auto_mode,
  input  logic [GATE_WIDTH-1:0] gate_cycles,
  output logic                  ctr_reset,
  output logic                  gate,
  output logic [1:0]            counter_select,
  output logic                  load,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_LOAD   = 3'd4;
  localparam logic [2:0] S_SHIFT  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // The counter runs down from (length-1); a captured gate length of 0 wraps to
  // all-ones, which is exactly 2^GATE_WIDTH cycles.
  localparam int W_F   = $clog2(FRAME_BITS + 1);
  localparam int W_C   = $clog2(CLEAR_CYCLES + 1);
  localparam int W_S   = $clog2(SETTLE_CYCLES + 1);
  localparam int W_FC  = (W_F > W_C) ? W_F : W_C;
  localparam int W_FCS = (W_FC > W_S) ? W_FC : W_S;
  localparam int CNT_W = (GATE_WIDTH > W_FCS) ? GATE_WIDTH : W_FCS;

  logic [2:0]            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [1:0]            chan, chan_n;
  logic [GATE_WIDTH-1:0] glen, glen_n;
  logic [GATE_WIDTH-1:0] glen_m1;

  assign glen_m1 = glen - GATE_WIDTH'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    chan_n  = chan;
    glen_n  = glen;
    case (state)
      S_IDLE: begin
        if (start || auto_mode) begin
          state_n = S_CLEAR;
          cnt_n   = CNT_W'(CLEAR_CYCLES - 1);
          glen_n  = gate_cycles;
        end
      end
      S_CLEAR: begin
        if (cnt == '0) begin
          state_n = S_GATE;
          cnt_n   = CNT_W'(glen_m1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_GATE: begin
        if (cnt == '0) begin
          state_n = S_SETTLE;
          cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
          chan_n  = 2'd0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          state_n = S_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_LOAD: begin
        state_n = S_SHIFT;
        cnt_n   = CNT_W'(FRAME_BITS - 1);
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          if (chan < 2'(CHANNELS - 1)) begin
            chan_n  = chan + 2'd1;
            state_n = S_LOAD;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (auto_mode) begin
          state_n = S_CLEAR;
          cnt_n   = CNT_W'(CLEAR_CYCLES - 1);
          glen_n  = gate_cycles;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every strobe comes straight off a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      chan           <= 2'd0;
      glen           <= '0;
      ctr_reset      <= 1'b0;
      gate           <= 1'b0;
      load           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      counter_select <= 2'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      chan      <= chan_n;
      glen      <= glen_n;
      ctr_reset <= (state_n == S_CLEAR);
      gate      <= (state_n == S_GATE);
      load      <= (state_n == S_LOAD);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
      if (state_n == S_SETTLE || state_n == S_LOAD || state_n == S_SHIFT)
        counter_select <= chan_n;
    end
  end

endmodule
